wb_uart_master: RTL and testbench

WB_UART_MASTER -- requirements
Module: wb_uart_master

---
 rtl/wb_uart_master.sv | 188 ++++++++++++++++++
 tb/tb_wb_uart_master.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_uart_master.sv
// Byte-stream to Wishbone bridge: decodes 0x57 (write) / 0x52 (read) command
// frames, runs one pipelined single-beat transfer, and answers over the byte link.
module wb_uart_master #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_busy,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [31:0] o_wb_addr,
    output logic [31:0] o_wb_data,
    output logic [3:0]  o_wb_sel,
    input  logic        i_wb_stall,
    input  logic        i_wb_ack,
    input  logic [31:0] i_wb_data,
    output logic        o_busy
);

    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] RSP_OK  = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h45;

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        BUS_REQ,
        BUS_WAIT,
        RESP_SEND,
        RESP_GAP
    } state_e;

    state_e           state_q,     state_d;
    logic             we_q,        we_d;
    logic [1:0]       byte_cnt_q,  byte_cnt_d;
    logic [31:0]      addr_q,      addr_d;
    logic [31:0]      data_q,      data_d;
    logic [31:0]      resp_q,      resp_d;
    logic [2:0]       resp_left_q, resp_left_d;
    logic [TMO_W-1:0] tmo_q,       tmo_d;
    logic             cyc_q,       cyc_d;
    logic             stb_q,       stb_d;
    logic [3:0]       sel_q,       sel_d;
    logic             busy_q,      busy_d;
    logic             tmo_hit;
    logic             tx_fire;

    always_comb begin
        // NOTE: every variable gets a default before the case, so no path can
        // leave one unassigned and infer a latch.
        state_d     = state_q;
        we_d        = we_q;
        byte_cnt_d  = byte_cnt_q;
        addr_d      = addr_q;
        data_d      = data_q;
        resp_d      = resp_q;
        resp_left_d = resp_left_q;
        tmo_d       = tmo_q;
        tx_fire     = 1'b0;
        // tmo_q counts bus cycles already spent, so this is the TIMEOUT_CYCLES-th one.
        tmo_hit     = (tmo_q == TMO_LAST);

        case (state_q)
            IDLE: begin
                if (i_rx_valid && (i_rx_data == CMD_WR || i_rx_data == CMD_RD)) begin
                    we_d       = (i_rx_data == CMD_WR);
                    byte_cnt_d = '0;
                    state_d    = ADDR;
                end
            end
            ADDR: begin
                if (i_rx_valid) begin
                    addr_d     = {addr_q[23:0], i_rx_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        tmo_d   = '0;
                        state_d = we_q ? DATA : BUS_REQ;
                    end
                end
            end
            DATA: begin
                if (i_rx_valid) begin
                    data_d     = {data_q[23:0], i_rx_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        tmo_d   = '0;
                        state_d = BUS_REQ;
                    end
                end
            end
            BUS_REQ: begin
                tmo_d = tmo_q + 1'b1;
                if (tmo_hit) begin
                    resp_d      = {RSP_ERR, 24'h0};
                    resp_left_d = 3'd1;
                    state_d     = RESP_SEND;
                end else if (!i_wb_stall) begin
                    state_d = BUS_WAIT;
                end
            end
            BUS_WAIT: begin
                tmo_d = tmo_q + 1'b1;
                // An ack on the final counted cycle still wins over the timeout.
                if (i_wb_ack) begin
                    resp_d      = we_q ? {RSP_OK, 24'h0} : i_wb_data;
                    resp_left_d = we_q ? 3'd1 : 3'd4;
                    state_d     = RESP_SEND;
                end else if (tmo_hit) begin
                    resp_d      = {RSP_ERR, 24'h0};
                    resp_left_d = 3'd1;
                    state_d     = RESP_SEND;
                end
            end
            RESP_SEND: begin
                if (!i_tx_busy) begin
                    tx_fire     = 1'b1;
                    resp_d      = {resp_q[23:0], 8'h00};
                    resp_left_d = resp_left_q - 3'd1;
                    state_d     = RESP_GAP;
                end
            end
            RESP_GAP: begin
                state_d = (resp_left_q == 3'd0) ? IDLE : RESP_SEND;
            end
            default: state_d = IDLE;
        endcase

        cyc_d  = (state_d == BUS_REQ) || (state_d == BUS_WAIT);
        stb_d  = (state_d == BUS_REQ);
        sel_d  = cyc_d ? 4'hF : 4'h0;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk) begin
        // NOTE: non-blocking assignments keep every flop sampling the values
        // from before this edge, independent of statement order.
        if (i_rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            byte_cnt_q  <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            resp_q      <= '0;
            resp_left_q <= '0;
            tmo_q       <= '0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            sel_q       <= 4'h0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            byte_cnt_q  <= byte_cnt_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            resp_q      <= resp_d;
            resp_left_q <= resp_left_d;
            tmo_q       <= tmo_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            sel_q       <= sel_d;
            busy_q      <= busy_d;
        end
    end

    // The strobe follows i_tx_busy in the same cycle so a byte is never
    // offered to a transmitter that has just gone busy.
    assign o_tx_valid = tx_fire;
    assign o_tx_data  = resp_q[31:24];
    assign o_wb_cyc   = cyc_q;
    assign o_wb_stb   = stb_q;
    assign o_wb_we    = we_q;
    assign o_wb_addr  = addr_q;
    assign o_wb_data  = data_q;
    assign o_wb_sel   = sel_q;
    assign o_busy     = busy_q;

endmodule

// File: tb/tb_wb_uart_master.sv
// Bench for wb_uart_master: directed command frames, a reactive Wishbone slave
// and a frame/queue level model compared against the DUT every cycle.
module tb_wb_uart_master;

    localparam int TMO = 8;
    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] RSP_OK  = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h45;

    logic        clk        = 1'b0;
    logic        i_rst      = 1'b1;
    logic [7:0]  i_rx_data  = 8'h00;
    logic        i_rx_valid = 1'b0;
    logic        i_tx_busy  = 1'b0;
    logic        i_wb_stall = 1'b0;
    logic        i_wb_ack   = 1'b0;
    logic [31:0] i_wb_data  = 32'h0;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic        o_wb_we;
    logic [31:0] o_wb_addr;
    logic [31:0] o_wb_data;
    logic [3:0]  o_wb_sel;
    logic        o_busy;

    always #5 clk = ~clk;

    wb_uart_master #(.TIMEOUT_CYCLES(TMO)) dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_rx_data  (i_rx_data),
        .i_rx_valid (i_rx_valid),
        .o_tx_data  (o_tx_data),
        .o_tx_valid (o_tx_valid),
        .i_tx_busy  (i_tx_busy),
        .o_wb_cyc   (o_wb_cyc),
        .o_wb_stb   (o_wb_stb),
        .o_wb_we    (o_wb_we),
        .o_wb_addr  (o_wb_addr),
        .o_wb_data  (o_wb_data),
        .o_wb_sel   (o_wb_sel),
        .i_wb_stall (i_wb_stall),
        .i_wb_ack   (i_wb_ack),
        .i_wb_data  (i_wb_data),
        .o_busy     (o_busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, wanted %h", name, act, exp);
        end
    endtask

    // Slave behaviour, set by the directed tests.
    int          stall_cfg = 0;
    int          ack_delay = 2;
    bit          ack_en    = 1'b1;
    bit          ack_force = 1'b0;
    logic [31:0] rdata     = 32'h0;
    int          stall_n   = 0;
    int          wait_n    = 0;

    initial forever begin
        @(posedge clk);
        #2;
        if (o_wb_stb) begin
            wait_n     = 0;
            i_wb_stall = (stall_n < stall_cfg);
            if (stall_n < stall_cfg) stall_n++;
            i_wb_ack   = ack_force;
        end else if (o_wb_cyc) begin
            stall_n    = 0;
            i_wb_stall = 1'b0;
            wait_n++;
            i_wb_ack   = ack_force || (ack_en && wait_n == ack_delay);
        end else begin
            stall_n    = 0;
            wait_n     = 0;
            i_wb_stall = 1'b0;
            i_wb_ack   = ack_force;
        end
        i_wb_data = rdata;
    end

    // Observation logs used by the literal checks.
    int          stb_cycles = 0;
    int          cyc_cycles = 0;
    logic [31:0] log_addr   = 32'h0;
    logic [31:0] log_data   = 32'h0;
    logic        log_we     = 1'b0;
    logic [3:0]  log_sel    = 4'h0;
    logic [7:0]  tx_log[$];

    // Model: a frame collector, a bus phase measured in elapsed cycles, and a
    // response byte queue drained one byte per two cycles.
    typedef enum {M_IDLE, M_FRAME, M_BUS, M_RESP} mphase_e;
    mphase_e    ph      = M_IDLE;
    logic [7:0] frame[$];
    logic [7:0] resp[$];
    int         bus_n   = 0;
    bit         acc     = 1'b0;
    bit         gap     = 1'b0;
    bit         m_valid = 1'b0;
    bit         prev_txv = 1'b0;
    bit         e_cyc, e_stb, e_busy, e_txv, e_wr;

    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            e_cyc  = (ph == M_BUS);
            e_stb  = e_cyc && !acc;
            e_busy = (ph != M_IDLE);
            e_txv  = (ph == M_RESP) && !gap && !i_tx_busy;
            e_wr   = (frame.size() > 0) && (frame[0] == CMD_WR);
            check("wb_cyc", 32'(o_wb_cyc), 32'(e_cyc));
            check("wb_stb", 32'(o_wb_stb), 32'(e_stb));
            check("busy", 32'(o_busy), 32'(e_busy));
            check("tx_valid", 32'(o_tx_valid), 32'(e_txv));
            if (e_stb) begin
                check("wb_we", 32'(o_wb_we), 32'(e_wr));
                check("wb_addr", o_wb_addr, {frame[1], frame[2], frame[3], frame[4]});
                if (e_wr) check("wb_data", o_wb_data, {frame[5], frame[6], frame[7], frame[8]});
                check("wb_sel", 32'(o_wb_sel), 32'hF);
            end
            if (e_txv) check("tx_data", 32'(o_tx_data), 32'(resp[0]));
            if (o_tx_valid) check("tx_back_to_back", 32'(prev_txv), 0);
        end
        if (o_wb_stb === 1'b1) begin
            stb_cycles++;
            log_addr = o_wb_addr;
            log_data = o_wb_data;
            log_we   = o_wb_we;
            log_sel  = o_wb_sel;
        end
        if (o_wb_cyc === 1'b1) cyc_cycles++;
        if (o_tx_valid === 1'b1) tx_log.push_back(o_tx_data);
        prev_txv = (o_tx_valid === 1'b1);

        if (i_rst) begin
            ph = M_IDLE;
            frame.delete();
            resp.delete();
            acc     = 1'b0;
            gap     = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            case (ph)
                M_IDLE: if (i_rx_valid && (i_rx_data == CMD_WR || i_rx_data == CMD_RD)) begin
                    frame.delete();
                    frame.push_back(i_rx_data);
                    ph = M_FRAME;
                end
                M_FRAME: if (i_rx_valid) begin
                    frame.push_back(i_rx_data);
                    if (frame.size() == ((frame[0] == CMD_WR) ? 9 : 5)) begin
                        ph    = M_BUS;
                        bus_n = 0;
                        acc   = 1'b0;
                    end
                end
                M_BUS: begin
                    bus_n++;
                    if (acc && i_wb_ack) begin
                        resp.delete();
                        if (frame[0] == CMD_WR) resp.push_back(RSP_OK);
                        else for (int i = 3; i >= 0; i--) resp.push_back(i_wb_data[i*8 +: 8]);
                        ph  = M_RESP;
                        gap = 1'b0;
                    end else if (bus_n == TMO) begin
                        resp.delete();
                        resp.push_back(RSP_ERR);
                        ph  = M_RESP;
                        gap = 1'b0;
                    end else if (!acc && !i_wb_stall) begin
                        acc = 1'b1;
                    end
                end
                M_RESP: begin
                    if (gap) begin
                        gap = 1'b0;
                        if (resp.size() == 0) ph = M_IDLE;
                    end else if (!i_tx_busy) begin
                        void'(resp.pop_front());
                        gap = 1'b1;
                    end
                end
                default: ph = M_IDLE;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        tick();
        i_rx_valid = 1'b0;
    endtask

    task automatic send_frame(input bit wr, input logic [31:0] addr, input logic [31:0] data);
        send_byte(wr ? CMD_WR : CMD_RD);
        for (int i = 3; i >= 0; i--) send_byte(addr[i*8 +: 8]);
        if (wr) for (int i = 3; i >= 0; i--) send_byte(data[i*8 +: 8]);
    endtask

    task automatic clear_logs();
        stb_cycles = 0;
        cyc_cycles = 0;
        tx_log.delete();
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (o_busy && k < 200) begin
            tick();
            k++;
        end
        check({name, "_idle"}, 32'(o_busy), 0);
    endtask

    task automatic wait_bus_wait(input string name);
        int k = 0;
        while (!(o_wb_cyc && !o_wb_stb) && k < 50) begin
            tick();
            k++;
        end
        check({name, "_reach_wait"}, 32'(o_wb_cyc && !o_wb_stb), 1);
    endtask

    // Expected bytes packed MSB first in exp; n of them.
    task automatic check_tx(input string name, input int n, input logic [31:0] exp);
        check({name, "_tx_count"}, tx_log.size(), n);
        for (int i = 0; i < n && i < tx_log.size(); i++)
            check({name, "_tx_byte"}, 32'(tx_log[i]), 32'(exp[(n-1-i)*8 +: 8]));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: bench did not finish, got timeout, wanted completion");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst = 1'b1;
        repeat (2) tick();
        check("rst_cyc", 32'(o_wb_cyc), 0);
        check("rst_stb", 32'(o_wb_stb), 0);
        check("rst_busy", 32'(o_busy), 0);
        check("rst_tx_valid", 32'(o_tx_valid), 0);
        check("rst_addr", o_wb_addr, 0);
        i_rst = 1'b0;
        tick();

        // Write, no stall, ack on the second wait cycle.
        clear_logs();
        stall_cfg = 0; ack_delay = 2; ack_en = 1'b1;
        send_frame(1'b1, 32'h0000_8010, 32'hDEAD_BEEF);
        wait_idle("wr");
        check("wr_stb_cycles", stb_cycles, 1);
        check("wr_addr", log_addr, 32'h0000_8010);
        check("wr_data", log_data, 32'hDEAD_BEEF);
        check("wr_we", 32'(log_we), 1);
        check("wr_sel", 32'(log_sel), 32'hF);
        check_tx("wr", 1, 32'h4B);

        // Read with three stall cycles; response held back by a busy transmitter.
        clear_logs();
        stall_cfg = 3; ack_delay = 2; rdata = 32'h1234_5678;
        i_tx_busy = 1'b1;
        send_frame(1'b0, 32'h0000_2004, 32'h0);
        wait_bus_wait("rd");
        for (int k = 0; k < 20 && o_wb_cyc; k++) tick();
        repeat (4) tick();
        check("rd_held_tx_count", tx_log.size(), 0);
        check("rd_held_busy", 32'(o_busy), 1);
        i_tx_busy = 1'b0;
        wait_idle("rd");
        check("rd_stb_cycles", stb_cycles, 4);
        check("rd_addr", log_addr, 32'h0000_2004);
        check("rd_we", 32'(log_we), 0);
        check_tx("rd", 4, 32'h1234_5678);

        // No ack at all: cycle lasts exactly TMO cycles and answers with an error.
        clear_logs();
        stall_cfg = 0; ack_en = 1'b0;
        send_frame(1'b0, 32'h0000_0040, 32'h0);
        wait_idle("tmo");
        check("tmo_cyc_cycles", cyc_cycles, 8);
        check_tx("tmo", 1, 32'h45);

        // Ack on the very cycle the counter reaches the limit is a success.
        clear_logs();
        ack_en = 1'b1; ack_delay = 7; rdata = 32'hA5A5_0F0F;
        send_frame(1'b0, 32'h0000_0080, 32'h0);
        wait_idle("edge_ok");
        check("edge_ok_cyc_cycles", cyc_cycles, 8);
        check_tx("edge_ok", 4, 32'hA5A5_0F0F);

        // One cycle later is too late.
        clear_logs();
        ack_delay = 8;
        send_frame(1'b0, 32'h0000_0084, 32'h0);
        wait_idle("edge_late");
        check("edge_late_cyc_cycles", cyc_cycles, 8);
        check_tx("edge_late", 1, 32'h45);

        // Junk in IDLE is dropped.
        clear_logs();
        send_byte(8'h00);
        send_byte(8'hFF);
        repeat (3) tick();
        check("junk_cyc_cycles", cyc_cycles, 0);
        check("junk_busy", 32'(o_busy), 0);

        // Bytes arriving during BUS_WAIT are ignored.
        clear_logs();
        ack_delay = 4;
        send_frame(1'b1, 32'h0000_0100, 32'h0102_0304);
        wait_bus_wait("ovl");
        send_byte(CMD_RD);
        send_byte(CMD_WR);
        wait_idle("ovl");
        check("ovl_stb_cycles", stb_cycles, 1);
        check_tx("ovl", 1, 32'h4B);

        clear_logs();
        ack_delay = 1; rdata = 32'hCAFE_F00D;
        send_frame(1'b0, 32'h0000_000C, 32'h0);
        wait_idle("after_ovl");
        check("after_ovl_addr", log_addr, 32'h0000_000C);
        check_tx("after_ovl", 4, 32'hCAFE_F00D);

        // Reset while waiting for ack; the late ack must not revive anything.
        clear_logs();
        ack_en = 1'b0;
        send_frame(1'b0, 32'h0000_0010, 32'h0);
        wait_bus_wait("mid_rst");
        repeat (2) tick();
        i_rst = 1'b1;
        tick();
        check("mid_rst_cyc", 32'(o_wb_cyc), 0);
        check("mid_rst_stb", 32'(o_wb_stb), 0);
        check("mid_rst_we", 32'(o_wb_we), 0);
        check("mid_rst_addr", o_wb_addr, 0);
        check("mid_rst_data", o_wb_data, 0);
        check("mid_rst_sel", 32'(o_wb_sel), 0);
        check("mid_rst_tx_valid", 32'(o_tx_valid), 0);
        check("mid_rst_tx_data", 32'(o_tx_data), 0);
        check("mid_rst_busy", 32'(o_busy), 0);
        i_rst = 1'b0;
        ack_force = 1'b1;
        tick();
        ack_force = 1'b0;
        repeat (6) tick();
        check("mid_rst_later_cyc", 32'(o_wb_cyc), 0);
        check("mid_rst_later_busy", 32'(o_busy), 0);
        check("mid_rst_tx_count", tx_log.size(), 0);

        // Normal operation resumes after the reset.
        clear_logs();
        ack_en = 1'b1; ack_delay = 1;
        send_frame(1'b1, 32'h0000_0004, 32'h0000_00AA);
        wait_idle("recover");
        check("recover_data", log_data, 32'h0000_00AA);
        check_tx("recover", 1, 32'h4B);

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
